tdc_sweep_ctrl: RTL and testbench

//  Stimulus/readout sequencer driving the TDC core from the system clock.
//  - Generates launch and capture strobes offset by a programmable cycle count.
//  - Drives the pulse-generator controls.
//  - Collects hw after a settle window and accumulates 2**ACC_LOG2 samples.
//  - Returns the sum over a valid/ready handshake.

---
 rtl/tdc_sweep_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tdc_sweep_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_sweep_ctrl.sv
// TDC sweep sequencer: launch/capture strobes, pulse-gen controls, sums 2**ACC_LOG2 hw samples (TDC_MINMAX_EN adds res_min/res_max).
// Latency: offset+SETTLE+1 cycles per sample; the result is held on res_valid until res_ready, and start is ignored while busy.
module tdc_sweep_ctrl #(
  parameter int N         = 64,
  parameter int OFF_W     = 8,
  parameter int ACC_LOG2  = 4,
  parameter int SETTLE    = 2,
  localparam int HW_W     = $clog2(N) + 1,
  localparam int SUM_W    = HW_W + ACC_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [OFF_W-1:0] offset,
  input  logic             cfg_src,
  input  logic             cfg_bypass,
  input  logic             cfg_alt,
  input  logic [HW_W-1:0]  hw,
  output logic             clk_launch,
  output logic             clk_capture,
  output logic             pg_src,
  output logic             pg_bypass,
  output logic             pg_in,
  output logic             pg_tog,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_sum,
  output logic [OFF_W-1:0] res_offset
`ifdef TDC_MINMAX_EN
  ,
  output logic [HW_W-1:0]  res_min,
  output logic [HW_W-1:0]  res_max
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_SETTLE, S_DONE
  } state_t;

  localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ST_W-1:0]     SETTLE_LOAD = ST_W'(SETTLE - 1);
  localparam logic [HW_W-1:0]     N_HW        = HW_W'(N);
  localparam logic [ACC_LOG2-1:0] LAST_SAMPLE = '1;

  state_t              state;
  logic [OFF_W-1:0]    off_q;
  logic                alt_q;
  logic [OFF_W-1:0]    wait_cnt;
  logic [ST_W-1:0]     settle_cnt;
  logic [ACC_LOG2-1:0] sample_cnt;
  logic [SUM_W-1:0]    acc;
  logic [HW_W-1:0]     hw_clamp;
  logic [SUM_W-1:0]    acc_next;

  always_comb begin
    hw_clamp = hw;
    if (hw > N_HW) hw_clamp = N_HW;
    acc_next = acc + SUM_W'(hw_clamp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      off_q       <= '0;
      alt_q       <= 1'b0;
      wait_cnt    <= '0;
      settle_cnt  <= '0;
      sample_cnt  <= '0;
      acc         <= '0;
      clk_launch  <= 1'b0;
      clk_capture <= 1'b0;
      pg_src      <= 1'b0;
      pg_bypass   <= 1'b0;
      pg_in       <= 1'b0;
      pg_tog      <= 1'b0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_sum     <= '0;
      res_offset  <= '0;
`ifdef TDC_MINMAX_EN
      res_min     <= N_HW;
      res_max     <= '0;
`endif
    end else begin
      clk_launch  <= 1'b0;
      clk_capture <= 1'b0;
      if (!en) begin
        // Abort: drop everything, including any unconsumed result
        state      <= S_IDLE;
        acc        <= '0;
        sample_cnt <= '0;
        pg_src     <= 1'b0;
        pg_bypass  <= 1'b0;
        pg_in      <= 1'b0;
        pg_tog     <= 1'b0;
        busy       <= 1'b0;
        res_valid  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state       <= S_LAUNCH;
              off_q       <= offset;
              alt_q       <= cfg_alt;
              acc         <= '0;
              sample_cnt  <= '0;
              clk_launch  <= 1'b1;
              clk_capture <= (offset == '0);
              pg_src      <= cfg_src;
              pg_bypass   <= cfg_bypass;
              pg_tog      <= cfg_alt;
              pg_in       <= 1'b1;
              busy        <= 1'b1;
`ifdef TDC_MINMAX_EN
              res_min     <= N_HW;
              res_max     <= '0;
`endif
            end
          end
          S_LAUNCH: begin
            // Capture lands exactly off_q cycles after launch; offset 1 needs no WAIT cycle
            if (off_q == '0) begin
              state      <= S_SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end else if (off_q == OFF_W'(1)) begin
              state       <= S_CAPTURE;
              clk_capture <= 1'b1;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= off_q - OFF_W'(1);
            end
          end
          S_WAIT: begin
            if (wait_cnt == OFF_W'(1)) begin
              state       <= S_CAPTURE;
              clk_capture <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt - OFF_W'(1);
            end
          end
          S_CAPTURE: begin
            state      <= S_SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
          S_SETTLE: begin
            if (settle_cnt != '0) begin
              settle_cnt <= settle_cnt - ST_W'(1);
            end else begin
              acc <= acc_next;
`ifdef TDC_MINMAX_EN
              if (hw_clamp < res_min) res_min <= hw_clamp;
              if (hw_clamp > res_max) res_max <= hw_clamp;
`endif
              if (sample_cnt == LAST_SAMPLE) begin
                state      <= S_DONE;
                res_valid  <= 1'b1;
                res_sum    <= acc_next;
                res_offset <= off_q;
              end else begin
                state       <= S_LAUNCH;
                sample_cnt  <= sample_cnt + ACC_LOG2'(1);
                clk_launch  <= 1'b1;
                clk_capture <= (off_q == '0);
                if (alt_q) pg_in <= ~pg_in;
              end
            end
          end
          S_DONE: begin
            if (res_ready) begin
              state     <= S_IDLE;
              res_valid <= 1'b0;
              busy      <= 1'b0;
              pg_src    <= 1'b0;
              pg_bypass <= 1'b0;
              pg_in     <= 1'b0;
              pg_tog    <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdc_sweep_ctrl.sv
// Directed bench for tdc_sweep_ctrl: strobe timing, sums, clamp, abort and handshake corner cases.
module tb_tdc_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, start, cfg_src, cfg_bypass, cfg_alt, res_ready;
  logic [7:0]  offset;
  logic [6:0]  hw;
  logic        clk_launch, clk_capture, pg_src, pg_bypass, pg_in, pg_tog, busy, res_valid;
  logic [10:0] res_sum;
  logic [7:0]  res_offset;
`ifdef TDC_MINMAX_EN
  logic [6:0]  res_min, res_max;
`endif

  int checks = 0;
  int errors = 0;

  tdc_sweep_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .offset(offset),
    .cfg_src(cfg_src), .cfg_bypass(cfg_bypass), .cfg_alt(cfg_alt), .hw(hw),
    .clk_launch(clk_launch), .clk_capture(clk_capture), .pg_src(pg_src),
    .pg_bypass(pg_bypass), .pg_in(pg_in), .pg_tog(pg_tog), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_offset(res_offset)
`ifdef TDC_MINMAX_EN
    , .res_min(res_min), .res_max(res_max)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the first cycle after start is taken (index 1)
  task automatic pulse_start(input logic [7:0] off);
    start = 1'b1; offset = off; tick(); start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (!res_valid && cycles < budget) begin tick(); cycles++; end
  endtask

  task automatic drain();
    res_ready = 1'b1; tick(); res_ready = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b1; offset = 8'd5; hw = 7'd20;
    cfg_src = 1'b1; cfg_bypass = 1'b1; cfg_alt = 1'b1; res_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({clk_launch, clk_capture, pg_src, pg_bypass, pg_in, pg_tog, busy, res_valid, res_sum, res_offset} !== 27'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got launch=%b cap=%b src=%b byp=%b in=%b tog=%b busy=%b vld=%b sum=%0d off=%0d, need all 0",
                 i, clk_launch, clk_capture, pg_src, pg_bypass, pg_in, pg_tog, busy, res_valid, res_sum, res_offset);
      end
    end
`ifdef TDC_MINMAX_EN
    checks++;
    if (res_min !== 7'd64 || res_max !== 7'd0) begin
      errors++; $display("FAIL reset_minmax: got min=%0d max=%0d, need 64/0", res_min, res_max);
    end
`endif
    start = 1'b0; rst = 1'b0; tick();
    checks++;
    if (busy !== 1'b0 || clk_launch !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored: got busy=%b launch=%b, need 0/0", busy, clk_launch);
    end
  endtask

  task automatic test_timing();
    int cyc;
    logic el, ec;
    hw = 7'd20; cfg_src = 1'b1; cfg_bypass = 1'b0; cfg_alt = 1'b1;
    pulse_start(8'd3);
    checks++;
    if (busy !== 1'b1 || pg_src !== 1'b1 || pg_bypass !== 1'b0 || pg_tog !== 1'b1) begin
      errors++; $display("FAIL timing_cfg: got busy=%b src=%b byp=%b tog=%b, need 1/1/0/1", busy, pg_src, pg_bypass, pg_tog);
    end
    for (int i = 1; i <= 13; i++) begin
      el = (i == 1 || i == 7 || i == 13);
      ec = (i == 4 || i == 10);
      checks++;
      if (clk_launch !== el || clk_capture !== ec) begin
        errors++; $display("FAIL timing_strobes idx %0d: got launch=%b cap=%b, need %b/%b", i, clk_launch, clk_capture, el, ec);
      end
      if (i == 1 || i == 7 || i == 13) begin
        checks++;
        if (pg_in !== (i != 7)) begin
          errors++; $display("FAIL timing_pg_in idx %0d: got %b, need %b", i, pg_in, (i != 7));
        end
      end
      if (i < 13) tick();
    end
    wait_valid(200, cyc);
    checks++;
    if (13 + cyc !== 97) begin
      errors++; $display("FAIL timing_result_latency: got res_valid at idx %0d, need 97", 13 + cyc);
    end
    checks++;
    if (res_sum !== 11'd320 || res_offset !== 8'd3) begin
      errors++; $display("FAIL timing_sum: got sum=%0d off=%0d, need 320/3", res_sum, res_offset);
    end
    drain();
  endtask

  task automatic test_sum_hold();
    int cyc;
    hw = 7'd20; cfg_src = 1'b0; cfg_bypass = 1'b1; cfg_alt = 1'b0;
    pulse_start(8'd5);
    offset = 8'd99;
    checks++;
    if (pg_in !== 1'b1 || pg_tog !== 1'b0 || pg_bypass !== 1'b1) begin
      errors++; $display("FAIL sum_cfg: got in=%b tog=%b byp=%b, need 1/0/1", pg_in, pg_tog, pg_bypass);
    end
    for (int i = 1; i < 9; i++) tick();
    checks++;
    if (clk_launch !== 1'b1 || pg_in !== 1'b1) begin
      errors++; $display("FAIL sum_second_launch: got launch=%b in=%b, need 1/1", clk_launch, pg_in);
    end
    wait_valid(300, cyc);
    checks++;
    if (res_valid !== 1'b1 || res_sum !== 11'd320 || res_offset !== 8'd5) begin
      errors++; $display("FAIL sum_result: got vld=%b sum=%0d off=%0d, need 1/320/5", res_valid, res_sum, res_offset);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || busy !== 1'b1 || res_sum !== 11'd320 || res_offset !== 8'd5) begin
        errors++; $display("FAIL sum_hold cycle %0d: got vld=%b busy=%b sum=%0d off=%0d, need 1/1/320/5", i, res_valid, busy, res_sum, res_offset);
      end
    end
    res_ready = 1'b1; start = 1'b1; offset = 8'd7; tick();
    res_ready = 1'b0; start = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || clk_launch !== 1'b0 || pg_src !== 1'b0) begin
      errors++; $display("FAIL sum_handshake: got vld=%b busy=%b launch=%b src=%b, need 0/0/0/0", res_valid, busy, clk_launch, pg_src);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || clk_launch !== 1'b0) begin
      errors++; $display("FAIL sum_start_on_handshake: got busy=%b launch=%b, need 0/0", busy, clk_launch);
    end
  endtask

  task automatic test_offset0();
    int cyc;
    logic e;
    hw = 7'd20; cfg_alt = 1'b1;
    pulse_start(8'd0);
    for (int i = 1; i <= 4; i++) begin
      e = (i == 1 || i == 4);
      checks++;
      if (clk_launch !== e || clk_capture !== e) begin
        errors++; $display("FAIL offset0_strobes idx %0d: got launch=%b cap=%b, need %b/%b", i, clk_launch, clk_capture, e, e);
      end
      if (i < 4) tick();
    end
    wait_valid(100, cyc);
    checks++;
    if (4 + cyc !== 49 || res_sum !== 11'd320 || res_offset !== 8'd0) begin
      errors++; $display("FAIL offset0_result: got idx=%0d sum=%0d off=%0d, need 49/320/0", 4 + cyc, res_sum, res_offset);
    end
    drain();
  endtask

  task automatic test_alternate();
    int cyc, n;
    cfg_alt = 1'b1;
    pulse_start(8'd0);
    n = 0; cyc = 0;
    while (!res_valid && cyc < 100) begin
      if (clk_launch) begin hw = n[0] ? 7'd40 : 7'd5; n++; end
      tick(); cyc++;
    end
    checks++;
    if (res_valid !== 1'b1 || n !== 16 || res_sum !== 11'd360) begin
      errors++; $display("FAIL alt_sum: got vld=%b launches=%0d sum=%0d, need 1/16/360", res_valid, n, res_sum);
    end
`ifdef TDC_MINMAX_EN
    checks++;
    if (res_min !== 7'd5 || res_max !== 7'd40) begin
      errors++; $display("FAIL alt_minmax: got min=%0d max=%0d, need 5/40", res_min, res_max);
    end
`endif
    drain();
  endtask

  task automatic test_clamp();
    int cyc;
    hw = 7'd64;
    pulse_start(8'd0);
    wait_valid(100, cyc);
    checks++;
    if (res_valid !== 1'b1 || res_sum !== 11'd1024) begin
      errors++; $display("FAIL clamp_at_n: got vld=%b sum=%0d, need 1/1024", res_valid, res_sum);
    end
    drain();
    hw = 7'd100;
    pulse_start(8'd255);
    for (int i = 1; i < 255; i++) tick();
    checks++;
    if (clk_capture !== 1'b0) begin
      errors++; $display("FAIL maxoff_early_capture: got cap=%b at idx 255, need 0", clk_capture);
    end
    tick();
    checks++;
    if (clk_capture !== 1'b1) begin
      errors++; $display("FAIL maxoff_capture: got cap=%b at idx 256, need 1", clk_capture);
    end
    wait_valid(5000, cyc);
    checks++;
    if (res_valid !== 1'b1 || res_sum !== 11'd1024 || res_offset !== 8'd255) begin
      errors++; $display("FAIL clamp_over_n: got vld=%b sum=%0d off=%0d, need 1/1024/255", res_valid, res_sum, res_offset);
    end
`ifdef TDC_MINMAX_EN
    checks++;
    if (res_min !== 7'd64 || res_max !== 7'd64) begin
      errors++; $display("FAIL clamp_minmax: got min=%0d max=%0d, need 64/64", res_min, res_max);
    end
`endif
    drain();
  endtask

  task automatic test_abort();
    int cyc;
    bit seen;
    hw = 7'd20; cfg_src = 1'b1; cfg_alt = 1'b1;
    pulse_start(8'd10);
    tick(); tick();
    en = 1'b0; tick();
    checks++;
    if ({busy, clk_launch, clk_capture, pg_in, pg_src, pg_tog, res_valid} !== 7'd0) begin
      errors++; $display("FAIL abort_wait: got busy=%b launch=%b cap=%b in=%b src=%b tog=%b vld=%b, need all 0",
                         busy, clk_launch, clk_capture, pg_in, pg_src, pg_tog, res_valid);
    end
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_valid || clk_launch || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_result: got activity=%b after abort, need 0", seen);
    end
    hw = 7'd7;
    pulse_start(8'd2);
    tick(); tick();
    start = 1'b1; offset = 8'd9; tick(); start = 1'b0;
    wait_valid(200, cyc);
    checks++;
    if (4 + cyc !== 81 || res_sum !== 11'd112 || res_offset !== 8'd2) begin
      errors++; $display("FAIL restart_result: got idx=%0d sum=%0d off=%0d, need 81/112/2", 4 + cyc, res_sum, res_offset);
    end
    en = 1'b0; tick(); en = 1'b1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_done: got vld=%b busy=%b, need 0/0", res_valid, busy);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL abort_done_stays: got vld=%b, need 0", res_valid);
    end
    pulse_start(8'd4);
    tick(); tick();
    rst = 1'b1; tick();
    checks++;
    if ({clk_launch, clk_capture, pg_src, pg_in, pg_tog, busy, res_valid, res_sum, res_offset} !== 26'd0) begin
      errors++; $display("FAIL midrun_reset: got busy=%b in=%b src=%b sum=%0d off=%0d, need all 0", busy, pg_in, pg_src, res_sum, res_offset);
    end
    rst = 1'b0; tick();
    checks++;
    if (busy !== 1'b0 || clk_launch !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_idle: got busy=%b launch=%b, need 0/0", busy, clk_launch);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_sum_hold();
    test_offset0();
    test_alternate();
    test_clamp();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
